in_stream_gen: RTL and testbench

- Parametrised successor to the fixed 10x10 pixel source feeding the Hough front end.
- Streams a COLS x ROWS frame of PIX_W-bit pixels from an internal loadable buffer, in raster order.
- Output uses a Valid/Ready handshake with aligned Frame/Line/LastPix sideband.
- Supports single-shot or continuous frames, configurable horizontal/vertical blanking, and a graceful stop; sits between the test/load interface and the edge/accumulator pipeline.

---
 rtl/in_stream_gen_pkg.sv | 30 +++
 rtl/in_stream_gen_pixel_buffer.sv | 31 +++
 rtl/in_stream_gen.sv | 180 ++++++++++++++++++
 tb/tb_in_stream_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_stream_gen_pkg.sv
// Shared types and helpers for the parametrised pixel stream source.
// Holds the FSM state encoding, a constant-safe clog2 and default geometry.
package in_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_t;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_COLS  = 10;
    localparam int DEF_ROWS  = 10;

    // Ceiling log2, never below 1 so every counter keeps at least one bit.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/in_stream_gen_pixel_buffer.sv
// Frame store: one write port and one synchronous read port with read enable.
// The read register only updates when enabled, so a stalled beat stays stable.
module pixel_buffer
    import in_stream_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = DEF_COLS * DEF_ROWS,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [PIX_W-1:0] o_rd_data
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    // Storage write and registered read; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/in_stream_gen.sv
// Raster-order pixel source with Valid/Ready output, frame/line sideband,
// optional line/frame blanking, continuous mode and end-of-frame stop.
module in_stream_gen
    import in_stream_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int H_BLANK = 0,
    parameter int V_BLANK = 0,
    parameter int ADDR_W  = clog2(COLS * ROWS)
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic              Mode,
    input  logic              Stop,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [PIX_W-1:0]  WrData,
    output logic [PIX_W-1:0]  Pixel,
    output logic              Valid,
    input  logic              Ready,
    output logic              Frame,
    output logic              Line,
    output logic              LastPix,
    output logic              Busy
);

    localparam int DEPTH     = COLS * ROWS;
    localparam int COL_W     = clog2(COLS);
    localparam int ROW_W     = clog2(ROWS);
    localparam int LINE_GAP  = H_BLANK;
    localparam int FRAME_GAP = H_BLANK + V_BLANK;
    localparam int BLK_W     = clog2(FRAME_GAP + 2);

    // The FETCH cycle is the last idle cycle of a gap, so the blank state runs gap-1 cycles.
    localparam logic [BLK_W-1:0]  LINE_LOAD  = BLK_W'((LINE_GAP > 1) ? LINE_GAP - 2 : 0);
    localparam logic [BLK_W-1:0]  FRAME_LOAD = BLK_W'((FRAME_GAP > 1) ? FRAME_GAP - 2 : 0);
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_mode;
    logic               r_stop_pend;
    logic [BLK_W-1:0]   r_blank_cnt;

    logic               w_valid;
    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic [COL_W-1:0]   w_next_col;
    logic [ROW_W-1:0]   w_next_row;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_wr_en;
    logic [PIX_W-1:0]   w_rd_data;
    state_t             w_gap_state;
    logic [BLK_W-1:0]   w_gap_load;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(ADDR_W'(row) * ADDR_W'(COLS)) + ADDR_W'(col);
    endfunction

    assign w_valid    = (r_state == ST_STREAM);
    assign w_accept   = w_valid && Ready;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);
    assign w_next_col = w_last_col ? {COL_W{1'b0}} : r_col + COL_W'(1'b1);
    assign w_next_row = w_last_col ? (w_last_row ? {ROW_W{1'b0}} : r_row + ROW_W'(1'b1)) : r_row;

    // The next beat is read in the same cycle it is accepted, giving one beat per cycle.
    assign w_rd_en   = (r_state == ST_FETCH) || w_accept;
    assign w_rd_addr = (r_state == ST_FETCH) ? pix_addr(r_row, r_col) : pix_addr(w_next_row, w_next_col);
    assign w_wr_en   = WrEn && (r_state == ST_IDLE) && ({1'b0, WrAddr} < DEPTH_L);

    pixel_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_buffer (
        .i_clk     (Clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (WrAddr),
        .i_wr_data (WrData),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Where to go after an accepted end-of-line: straight on, via FETCH, or via a blank state.
    always_comb begin
        w_gap_state = ST_STREAM;
        w_gap_load  = {BLK_W{1'b0}};
        if (w_last_row) begin
            if (FRAME_GAP == 0) begin
                w_gap_state = ST_STREAM;
            end else if (FRAME_GAP == 1) begin
                w_gap_state = ST_FETCH;
            end else begin
                w_gap_state = (V_BLANK > 0) ? ST_VBLANK : ST_HBLANK;
                w_gap_load  = FRAME_LOAD;
            end
        end else begin
            if (LINE_GAP == 0) begin
                w_gap_state = ST_STREAM;
            end else if (LINE_GAP == 1) begin
                w_gap_state = ST_FETCH;
            end else begin
                w_gap_state = ST_HBLANK;
                w_gap_load  = LINE_LOAD;
            end
        end
    end

    // Main sequencer: state, raster position, mode latch, pending stop and blank countdown.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_col       <= {COL_W{1'b0}};
            r_row       <= {ROW_W{1'b0}};
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_blank_cnt <= {BLK_W{1'b0}};
        end else begin
            if (Stop && (r_state != ST_IDLE)) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state <= ST_FETCH;
                        r_mode  <= Mode;
                        r_col   <= {COL_W{1'b0}};
                        r_row   <= {ROW_W{1'b0}};
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (Ready) begin
                        r_col <= w_next_col;
                        r_row <= w_next_row;
                        // A stop arriving with the final beat still ends this frame.
                        if (w_last_col && w_last_row && (!r_mode || r_stop_pend || Stop)) begin
                            r_state     <= ST_IDLE;
                            r_stop_pend <= 1'b0;
                        end else if (w_last_col) begin
                            r_state     <= w_gap_state;
                            r_blank_cnt <= w_gap_load;
                        end
                    end
                end
                ST_HBLANK, ST_VBLANK: begin
                    if (r_blank_cnt == {BLK_W{1'b0}}) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - BLK_W'(1'b1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Valid   = w_valid;
    assign Busy    = (r_state != ST_IDLE);
    assign Pixel   = w_valid ? w_rd_data : {PIX_W{1'b0}};
    assign Frame   = w_valid && (r_row == {ROW_W{1'b0}}) && (r_col == {COL_W{1'b0}});
    assign Line    = w_valid && (r_col == {COL_W{1'b0}});
    assign LastPix = w_valid && w_last_row && w_last_col;

endmodule

// File: tb/tb_in_stream_gen.sv
// Scoreboard bench for in_stream_gen on a 4x3 frame: one instance without blanking,
// one with H_BLANK=2/V_BLANK=3 whose beat timing is also scored.
module tb_in_stream_gen;

    localparam int NPIX = 12;
    localparam int AW   = 4;

    typedef struct packed {
        logic [7:0] pix;
        logic       frame;
        logic       line;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          n_reset, start0, start1, mode, stop, ready, wren0, wren1;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    pix0, pix1;
    logic          valid0, frame0, line0, last0, busy0;
    logic          valid1, frame1, line1, last1, busy1;

    beat_t      q0[$];
    beat_t      q1[$];
    int         q1_off[$];
    logic [7:0] mem [NPIX];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         acc0     = 0;
    int         cyc1     = 0;
    int         base1    = -1;
    logic       rand_ready = 1'b0;
    logic [15:0] pat = 16'b1001_1010_0011_0101;
    logic       stall0 = 1'b0;
    beat_t      held0, cur0, want0, cur1, want1;
    int         off1;

    always #5 clk = ~clk;

    in_stream_gen #(.PIX_W(8), .COLS(4), .ROWS(3), .H_BLANK(0), .V_BLANK(0)) dut0 (
        .Clk(clk), .nReset(n_reset), .Start(start0), .Mode(mode), .Stop(stop),
        .WrEn(wren0), .WrAddr(wr_addr), .WrData(wr_data),
        .Pixel(pix0), .Valid(valid0), .Ready(ready), .Frame(frame0), .Line(line0),
        .LastPix(last0), .Busy(busy0)
    );

    in_stream_gen #(.PIX_W(8), .COLS(4), .ROWS(3), .H_BLANK(2), .V_BLANK(3)) dut1 (
        .Clk(clk), .nReset(n_reset), .Start(start1), .Mode(mode), .Stop(stop),
        .WrEn(wren1), .WrAddr(wr_addr), .WrData(wr_data),
        .Pixel(pix1), .Valid(valid1), .Ready(1'b1), .Frame(frame1), .Line(line1),
        .LastPix(last1), .Busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame0();
        for (int j = 0; j < NPIX; j++) begin
            q0.push_back({mem[j], (j == 0), (j % 4 == 0), (j == NPIX - 1)});
        end
    endtask

    // Frame f of the blanked instance: lines are 4 beats + 2 idle, frames repeat every 21 cycles.
    task automatic push_frame1(input int f);
        for (int j = 0; j < NPIX; j++) begin
            q1.push_back({mem[j], (j == 0), (j % 4 == 0), (j == NPIX - 1)});
            q1_off.push_back(21 * f + (j / 4) * 6 + (j % 4));
        end
    endtask

    task automatic wait_q(input int which, input int level, input int budget, input string tag);
        int n;
        int sz;
        n  = 0;
        sz = (which == 0) ? q0.size() : q1.size();
        while (sz > level && n < budget) begin
            if (rand_ready) begin
                ready = pat[n % 16];
            end
            tick();
            n++;
            sz = (which == 0) ? q0.size() : q1.size();
        end
        ready = 1'b1;
        check_eq(tag, (sz <= level), 32'd1);
    endtask

    task automatic start_dut0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Scoreboard and stall-stability monitor for the unblanked instance.
    always @(negedge clk) begin
        cur0 = {pix0, frame0, line0, last0};
        if (!n_reset) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                check_eq("stall_valid0", valid0, 32'd1);
                check_eq("stall_hold0", cur0, held0);
            end
            stall0 = valid0 && !ready;
            held0  = cur0;
            if (valid0 && ready) begin
                acc0++;
                if (q0.size() == 0) begin
                    check_eq("extra_beat0", 32'd1, 32'd0);
                end else begin
                    want0 = q0.pop_front();
                    check_eq("beat0", cur0, want0);
                end
            end
        end
    end

    // Scoreboard for the blanked instance, including each beat's cycle offset.
    always @(negedge clk) begin
        cyc1++;
        cur1 = {pix1, frame1, line1, last1};
        if (n_reset && valid1) begin
            if (q1.size() == 0) begin
                check_eq("extra_beat1", 32'd1, 32'd0);
            end else begin
                want1 = q1.pop_front();
                off1  = q1_off.pop_front();
                if (base1 < 0) begin
                    base1 = cyc1;
                end
                check_eq("beat1", cur1, want1);
                check_eq("gap1", cyc1 - base1, off1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 1'b0; stop = 1'b0;
        ready = 1'b1; wren0 = 1'b0; wren1 = 1'b0; wr_addr = '0; wr_data = 8'd0;
        repeat (3) tick();
        check_eq("rst_valid0", valid0, 32'd0);
        check_eq("rst_busy0", busy0, 32'd0);
        check_eq("rst_pixel0", pix0, 32'd0);
        check_eq("rst_side0", {frame0, line0, last0}, 32'd0);
        check_eq("rst_valid1", valid1, 32'd0);
        check_eq("rst_busy1", busy1, 32'd0);
        n_reset = 1'b1;
        tick();

        for (int i = 0; i < NPIX; i++) begin
            mem[i]  = 8'(i + 10);
            wren0   = 1'b1;
            wren1   = 1'b1;
            wr_addr = AW'(i);
            wr_data = mem[i];
            tick();
        end
        wren0 = 1'b0;
        wren1 = 1'b0;

        // Single frame, always ready.
        acc0 = 0; mode = 1'b0;
        push_frame0();
        start_dut0();
        check_eq("fetch_no_valid", valid0, 32'd0);
        check_eq("busy_after_start", busy0, 32'd1);
        tick();
        check_eq("first_valid_latency", valid0, 32'd1);
        wait_q(0, 0, 40, "t1_drain");
        check_eq("t1_busy_done", busy0, 32'd0);
        check_eq("t1_accepts", acc0, 32'd12);

        // Single frame with a stalling consumer.
        repeat (2) tick();
        acc0 = 0;
        push_frame0();
        start_dut0();
        rand_ready = 1'b1;
        wait_q(0, 0, 300, "t2_drain");
        rand_ready = 1'b0;
        check_eq("t2_accepts", acc0, 32'd12);
        check_eq("t2_busy_done", busy0, 32'd0);

        // Blanked continuous stream, stopped during the second frame.
        base1 = -1; mode = 1'b1;
        push_frame1(0);
        push_frame1(1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_q(1, 6, 200, "t3_frame2");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_q(1, 0, 100, "t3_drain");
        check_eq("t3_busy_done", busy1, 32'd0);
        repeat (8) tick();
        check_eq("t3_quiet", {valid1, busy1}, 32'd0);

        // Continuous mode, stop during beat 5 finishes the frame.
        acc0 = 0; mode = 1'b1;
        push_frame0();
        start_dut0();
        wait_q(0, 7, 60, "t4_beat5");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_q(0, 0, 60, "t4_drain");
        check_eq("t4_busy_done", busy0, 32'd0);
        repeat (6) tick();
        check_eq("t4_quiet", {valid0, busy0}, 32'd0);
        check_eq("t4_accepts", acc0, 32'd12);

        // Start and Stop together in IDLE: Start wins, stream keeps going.
        acc0 = 0;
        push_frame0();
        push_frame0();
        start0 = 1'b1; stop = 1'b1;
        tick();
        start0 = 1'b0; stop = 1'b0;
        wait_q(0, 6, 80, "t4b_frame2");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_q(0, 0, 60, "t4b_drain");
        check_eq("t4b_busy_done", busy0, 32'd0);
        check_eq("t4b_accepts", acc0, 32'd24);

        // Write while busy is dropped; out-of-range write dropped; idle write lands.
        mode = 1'b0;
        push_frame0();
        start_dut0();
        tick();
        check_eq("t5_busy", busy0, 32'd1);
        wren0 = 1'b1; wr_addr = 4'd0; wr_data = 8'd99;
        tick();
        wren0 = 1'b0;
        wait_q(0, 0, 40, "t5_drain_a");
        push_frame0();
        start_dut0();
        wait_q(0, 0, 40, "t5_drain_b");
        wren0 = 1'b1; wr_addr = 4'd12; wr_data = 8'd77;
        tick();
        wr_addr = 4'd0; wr_data = 8'd99; mem[0] = 8'd99;
        tick();
        wren0 = 1'b0;
        push_frame0();
        start_dut0();
        wait_q(0, 0, 40, "t5_drain_c");

        // Reset mid-frame at beat 6, then restart from address 0.
        push_frame0();
        start_dut0();
        wait_q(0, 6, 40, "t6_beat6");
        n_reset = 1'b0;
        tick();
        check_eq("t6_valid", valid0, 32'd0);
        check_eq("t6_busy", busy0, 32'd0);
        check_eq("t6_pixel", pix0, 32'd0);
        check_eq("t6_side", {frame0, line0, last0}, 32'd0);
        q0.delete();
        n_reset = 1'b1;
        tick();
        push_frame0();
        start_dut0();
        wait_q(0, 0, 40, "t6_drain");
        check_eq("t6_busy_done", busy0, 32'd0);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
